fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time bursts of up to BURST_LEN
// writes into a downstream synchronous FIFO, with a fixed one-cycle arbitration gap.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
    logic [ID_W-1:0]       w_idx;
    logic [ID_W-1:0]       w_pick;
    logic                  w_any;
    logic                  w_grant;
    logic                  w_own_valid;
    logic                  w_last;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Descending scan so the requester closest to r_rr_ptr is the last (winning) match.
    always_comb begin
        w_any  = |req_valid;
        w_pick = r_rr_ptr;
        w_idx  = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = r_rr_ptr + ID_W'(k);
            if (req_valid[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    // Outputs are forced low while reset is high so an interrupted burst writes nothing.
    always_comb begin
        w_grant     = (r_state == StGrant) && !reset;
        w_own_valid = req_valid[r_owner];
        w_last      = (r_beat_cnt == LAST_BEAT);
        req_ready   = '0;
        if (w_grant) begin
            req_ready[r_owner] = !fifo_full;
        end
        fifo_wr_en   = w_grant && w_own_valid && !fifo_full;
        fifo_data_in = w_grant ? w_slice[r_owner] : '0;
        grant_valid  = w_grant;
        grant_id     = w_grant ? r_owner : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_owner    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= StGrant;
                    end
                end
                StGrant: begin
                    if (!w_own_valid) begin
                        r_state  <= StIdle;
                        r_rr_ptr <= r_owner + ID_W'(1);
                    end else if (!fifo_full) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state  <= StIdle;
                            r_rr_ptr <= r_owner + ID_W'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed checks of arbitration, bursts, backpressure, early release and reset,
// followed by a randomized in-order scoreboard of FIFO writes.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;

    logic [7:0]  word [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = word[i];
        end
    end

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .BURST_LEN  (4)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, check outputs mid-cycle, clock once and advance handshaken words.
    task automatic cyc(input logic rst, input logic [3:0] vld, input logic full,
                       input logic [3:0] e_rdy, input logic e_wr, input logic [7:0] e_data,
                       input logic e_gv, input logic [1:0] e_gid, input string tag);
        logic [3:0] hs;
        reset     = rst;
        req_valid = vld;
        fifo_full = full;
        #1;
        check_eq({tag, ".rdy"},  32'(req_ready),    32'(e_rdy));
        check_eq({tag, ".wr"},   32'(fifo_wr_en),   32'(e_wr));
        check_eq({tag, ".data"}, 32'(fifo_data_in), 32'(e_data));
        check_eq({tag, ".gv"},   32'(grant_valid),  32'(e_gv));
        check_eq({tag, ".gid"},  32'(grant_id),     32'(e_gid));
        hs = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) word[i] = word[i] + 8'd1;
        end
    endtask

    task automatic idle_cyc(input logic [3:0] vld, input string tag);
        cyc(1'b0, vld, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, tag);
    endtask

    task automatic do_reset();
        cyc(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, "reset");
    endtask

    initial begin
        int order [5];
        int beats;
        logic [3:0] vld;
        logic       full;
        logic [3:0] hs;

        for (int i = 0; i < 4; i++) word[i] = 8'h00;
        reset = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        do_reset();
        do_reset();

        // Single requester 2: two bursts separated by one idle cycle, then drop.
        word[2] = 8'hA0;
        idle_cyc(4'b0100, "t1_idle");
        for (int b = 0; b < 4; b++) begin
            cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA0 + 8'(b), 1'b1, 2'd2, "t1_beat");
        end
        idle_cyc(4'b0100, "t1_gap");
        cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA4, 1'b1, 2'd2, "t1_b4");
        cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA5, 1'b1, 2'd2, "t1_b5");
        cyc(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 8'hA6, 1'b1, 2'd2, "t1_drop");
        idle_cyc(4'b0000, "t1_end");

        // Round-robin with everyone valid.
        do_reset();
        word[0] = 8'h10; word[1] = 8'h20; word[2] = 8'h30; word[3] = 8'h40;
        order = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            idle_cyc(4'b1111, "t2_idle");
            for (int b = 0; b < 4; b++) begin
                cyc(1'b0, 4'b1111, 1'b0, 4'(1 << order[n]), 1'b1,
                    8'h10 * 8'(order[n] + 1) + 8'(b) + ((n == 4) ? 8'd4 : 8'd0),
                    1'b1, 2'(order[n]), "t2_beat");
            end
        end

        // Backpressure on requester 1 after its first beat.
        do_reset();
        word[1] = 8'h50;
        idle_cyc(4'b0010, "t3_idle");
        cyc(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h50, 1'b1, 2'd1, "t3_b0");
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 8'h51, 1'b1, 2'd1, "t3_stall");
        end
        for (int b = 1; b < 4; b++) begin
            cyc(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h50 + 8'(b), 1'b1, 2'd1, "t3_beat");
        end
        idle_cyc(4'b0010, "t3_rel");

        // Early drop by requester 3; pointer wraps to 0.
        do_reset();
        word[3] = 8'h60;
        word[0] = 8'h80;
        idle_cyc(4'b1000, "t4_idle");
        cyc(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h60, 1'b1, 2'd3, "t4_b0");
        cyc(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h61, 1'b1, 2'd3, "t4_b1");
        cyc(1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 8'h62, 1'b1, 2'd3, "t4_drop");
        idle_cyc(4'b1011, "t4_gap");
        cyc(1'b0, 4'b1011, 1'b0, 4'b0001, 1'b1, 8'h80, 1'b1, 2'd0, "t4_regrant");

        // Reset in the middle of a burst to requester 2.
        do_reset();
        word[2] = 8'h70;
        word[0] = 8'h90;
        idle_cyc(4'b0100, "t5_idle");
        cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h70, 1'b1, 2'd2, "t5_b0");
        cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h71, 1'b1, 2'd2, "t5_b1");
        cyc(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, "t5_rst");
        idle_cyc(4'b1111, "t5_after");
        cyc(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'h90, 1'b1, 2'd0, "t5_grant0");
        check_eq("t5_word2_kept", 32'(word[2]), 32'h72);

        // Random valid/full: writes must carry each requester's words in order.
        do_reset();
        for (int i = 0; i < 4; i++) word[i] = 8'(i * 8'h40);
        beats = 0;
        for (int c = 0; c < 400; c++) begin
            vld  = 4'($urandom);
            full = ($urandom_range(3) == 0);
            reset     = 1'b0;
            req_valid = vld;
            fifo_full = full;
            #1;
            hs = req_ready & req_valid;
            check_eq("sb_wr_hs", 32'(fifo_wr_en), 32'(|hs));
            if (fifo_wr_en) begin
                beats++;
                check_eq("sb_full", 32'(fifo_full), 32'd0);
                check_eq("sb_data", 32'(fifo_data_in), 32'(word[grant_id]));
                check_eq("sb_burst", 32'(beats <= 4), 32'd1);
            end
            if (!grant_valid) beats = 0;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) word[i] = word[i] + 8'd1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
